// File: rtl/pwm_dac_pkg.sv
// Shared constants for the PWM DAC channels: default period, fractional width
// and the counter reset value that makes the first enabled edge a load edge.
package pwm_dac_pkg;

  localparam int PWM_PERIOD_DEF = 156;
  localparam int PWM_PERIOD_MIN = 2;
  localparam int PWM_PERIOD_MAX = 1023;
  localparam int PWM_FRAC_W     = 8;

  // Parking the counter on the last position turns the next enabled edge into a wrap/load.
  function automatic int pwm_cnt_rst(input int period);
    return period - 1;
  endfunction

endpackage

// File: rtl/red_pitaya_pwm_dac.sv
// One PWM DAC channel: double-buffered 8-bit duty with a fractional error
// accumulator so the long-term duty is exactly cfg/256 for any PERIOD.
module red_pitaya_pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter  int PERIOD = PWM_PERIOD_DEF,
  localparam int CW     = $clog2(PERIOD + 1)
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       ena_i,
  input  logic [7:0] cfg_i,
  output logic       pwm_o,
  output logic       sync_o
);

  localparam int              SW       = PWM_FRAC_W + CW + 1;
  localparam logic [CW-1:0]   CNT_RST  = CW'(pwm_cnt_rst(PERIOD));
  localparam logic [SW-1:0]   PERIOD_W = SW'(PERIOD);

  if (PERIOD < PWM_PERIOD_MIN || PERIOD > PWM_PERIOD_MAX) begin : g_bad_period
    $error("red_pitaya_pwm_dac: PERIOD out of range 2..1023");
  end

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         high_q, high_d;
  logic [PWM_FRAC_W-1:0] acc_q, acc_d;
  logic                  pwm_q, pwm_d;
  logic                  sync_q, sync_d;
  logic [SW-1:0]         sum;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d  = cnt_q;
    high_d = high_q;
    acc_d  = acc_q;
    sum    = SW'(cfg_i) * PERIOD_W + SW'(acc_q);

    if (!ena_i) begin
      cnt_d  = CNT_RST;
      high_d = '0;
      acc_d  = '0;
    end else if (cnt_q == CNT_RST) begin
      cnt_d  = '0;
      high_d = CW'(sum >> PWM_FRAC_W);
      acc_d  = sum[PWM_FRAC_W-1:0];
    end else begin
      cnt_d  = cnt_q + CW'(1);
    end

    // Outputs follow the next-state values so the first sample of a period lands on the wrap edge.
    pwm_d  = ena_i && (cnt_d < high_d);
    sync_d = ena_i && (cnt_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous so
  // pwm_o drops the instant rstn_i falls, even mid-pulse.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q  <= CNT_RST;
      high_q <= '0;
      acc_q  <= '0;
      pwm_q  <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      high_q <= high_d;
      acc_q  <= acc_d;
      pwm_q  <= pwm_d;
      sync_q <= sync_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign sync_o = sync_q;

endmodule

// File: tb/tb_red_pitaya_pwm_dac.sv
// Directed bench for one PWM DAC channel: a behavioural model pushes expected
// pwm/sync per edge into a scoreboard, plus per-period high-time totals.
module tb_red_pitaya_pwm_dac;

  localparam int P = 156;

  logic       clk = 1'b0;
  logic       rstn_i;
  logic       ena_i;
  logic [7:0] cfg_i;
  logic       pwm_o;
  logic       sync_o;

  red_pitaya_pwm_dac #(.PERIOD(P)) dut (
    .clk_i  (clk),
    .rstn_i (rstn_i),
    .ena_i  (ena_i),
    .cfg_i  (cfg_i),
    .pwm_o  (pwm_o),
    .sync_o (sync_o)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] exp_q[$];
  int         hist[$];
  int         run_cnt = 0;
  bit         in_period = 1'b0;
  int         m_cnt = P - 1;
  int         m_high = 0;
  int         m_acc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = P - 1;
    m_high = 0;
    m_acc  = 0;
  endtask

  task automatic clear_hist();
    hist.delete();
    in_period = 1'b0;
    run_cnt   = 0;
  endtask

  // One clock: predict, push, let the edge happen, then pop and compare.
  task automatic tick();
    int         s;
    logic [1:0] e;
    if (!ena_i) begin
      model_reset();
    end else if (m_cnt == P - 1) begin
      s      = int'(cfg_i) * P + m_acc;
      m_cnt  = 0;
      m_high = s / 256;
      m_acc  = s % 256;
    end else begin
      m_cnt++;
    end
    exp_q.push_back({ena_i && (m_cnt < m_high), ena_i && (m_cnt == 0)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("pwm", 32'(pwm_o), 32'(e[1]));
    check("sync", 32'(sync_o), 32'(e[0]));
    if (sync_o === 1'b1) begin
      if (in_period) hist.push_back(run_cnt);
      in_period = 1'b1;
      run_cnt   = (pwm_o === 1'b1) ? 1 : 0;
    end else if (pwm_o === 1'b1) begin
      run_cnt++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int c);
    for (int i = 0; i < 2 * P && m_cnt != c; i++) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn_i = 1'b0;
    #1;
    check("rst_pwm", 32'(pwm_o), 32'd0);
    check("rst_sync", 32'(sync_o), 32'd0);
    model_reset();
    @(negedge clk);
    rstn_i = 1'b1;
  endtask

  task automatic check_hist(input string tag, input int idx, input int exp);
    if (idx < hist.size()) check(tag, 32'(hist[idx]), 32'(exp));
    else check({tag, "_missing"}, 32'(hist.size()), 32'(idx + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int tot;
    int mx;
    rstn_i = 1'b0;
    ena_i  = 1'b1;
    cfg_i  = 8'h00;

    // cfg=0: never high, sync every P clocks starting on the first edge
    do_reset();
    clear_hist();
    tick();
    check("t1_first_sync", 32'(sync_o), 32'd1);
    run(2 * P);
    check("t1_periods", 32'(hist.size()), 32'd2);
    check_hist("t1_high0", 0, 0);
    check_hist("t1_high1", 1, 0);

    // cfg=0x80: 78 high / 78 low
    cfg_i = 8'h80;
    run_to(P - 1);
    clear_hist();
    tick();
    run(2 * P);
    check_hist("t2_high0", 0, 78);
    check_hist("t2_high1", 1, 78);

    // cfg=0x01 from reset: 0,1,0,1,1
    cfg_i = 8'h01;
    do_reset();
    clear_hist();
    run(5 * P + 1);
    check_hist("t3_p0", 0, 0);
    check_hist("t3_p1", 1, 1);
    check_hist("t3_p2", 2, 0);
    check_hist("t3_p3", 3, 1);
    check_hist("t3_p4", 4, 1);

    // cfg=0xFF over 256 periods
    cfg_i = 8'hFF;
    do_reset();
    clear_hist();
    run(256 * P + 1);
    tot = 0;
    mx  = 0;
    foreach (hist[i]) begin
      tot += hist[i];
      if (hist[i] > mx) mx = hist[i];
    end
    check("t4_periods", 32'(hist.size()), 32'd256);
    check("t4_total", 32'(tot), 32'd39780);
    check("t4_max", 32'(mx), 32'(P));

    // Disable mid-pulse with acc=200, re-enable must start from acc=0
    run_to(P - 1);
    tick();
    run_to(10);
    check("t6_pwm_before", 32'(pwm_o), 32'd1);
    ena_i = 1'b0;
    tick();
    check("t6_pwm_dis", 32'(pwm_o), 32'd0);
    run(2);
    clear_hist();
    ena_i = 1'b1;
    tick();
    check("t6_resync", 32'(sync_o), 32'd1);
    run(P);
    check_hist("t6_high_fresh", 0, 155);

    // Mid-period cfg change and one-cycle glitch
    cfg_i = 8'h0F;
    do_reset();
    clear_hist();
    tick();
    run_to(40);
    cfg_i = 8'h9C;
    run_to(P - 1);
    tick();
    run_to(80);
    cfg_i = 8'h00;
    tick();
    cfg_i = 8'h9C;
    run_to(P - 1);
    tick();
    run_to(P - 1);
    tick();
    check_hist("t5_old_period", 0, 9);
    check_hist("t5_new_period", 1, 95);
    check_hist("t5_glitch_ignored", 2, 95);

    // Asynchronous reset while pwm is high
    run_to(20);
    check("t7_pwm_before", 32'(pwm_o), 32'd1);
    #2;
    rstn_i = 1'b0;
    #1;
    check("t7_async_pwm", 32'(pwm_o), 32'd0);
    check("t7_async_sync", 32'(sync_o), 32'd0);
    model_reset();
    cfg_i = 8'h80;
    @(negedge clk);
    rstn_i = 1'b1;
    clear_hist();
    run(P + 1);
    check_hist("t7_after_reset", 0, 78);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
